// File: rtl/mem_responder.sv
// Word-addressed memory behind the MAR/MDR port, with configurable
// wait states and one-cycle Ready/Err completion pulses.
module mem_responder #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       Address,
  input  logic              Read,
  input  logic              Write,
  input  logic [DATA_W-1:0] Data_in,
  output logic [DATA_W-1:0] Mdatain,
  output logic              Ready,
  output logic              Busy,
  output logic              Err
);

  localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] LIMIT = 32'(DEPTH);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t            state;
  state_t            state_n;
  logic [3:0]        cnt;
  logic [3:0]        cnt_n;
  logic              prev;
  logic              req;
  logic              accept;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] data_q;
  logic              rd_q;
  logic              wr_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  assign req    = (Read | Write) & ~prev;
  assign accept = (state == IDLE) & req;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      cnt   <= '0;
      prev  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      prev  <= Read | Write;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (WS == 4'd0) begin
            state_n = DONE;
          end else begin
            state_n = WAIT;
            cnt_n   = WS;
          end
        end
      end
      // <=1 also guards against a stuck zero count
      WAIT: begin
        if (cnt <= 4'd1) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    Busy  = (state == WAIT);
    Ready = (state == DONE);
    Err   = (state == DONE) & err_q;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      Mdatain <= '0;
    end else begin
      if (accept) begin
        addr_q <= Address[AW-1:0];
        data_q <= Data_in;
        rd_q   <= Read & ~Write;
        wr_q   <= Write & ~Read;
        err_q  <= (Read & Write) | (Address >= LIMIT);
      end
      if (state == DONE && rd_q) begin
        Mdatain <= err_q ? '0 : mem[addr_q];
      end
    end
  end

  // storage is never reset; a write only lands on a clean DONE exit
  always_ff @(posedge clk) begin
    if (clr && state == DONE && wr_q && !err_q) begin
      mem[addr_q] <= data_q;
    end
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Synchronous word-addressed memory that answers the datapath's memory port: it receives the MAR address, `Read`/`Write` strobes and MDR write data, and returns read data on `Mdatain`. Wait states are configurable, and a one-cycle `Ready` pulse marks completion. It replaces the bench-driven `Mdatain` stimulus so instruction fetch and load/store run against real storage.

## Interface
Parameters:
- `DATA_W`, 32: word width.
- `DEPTH`, 512: number of words; valid addresses are 0..DEPTH-1.
- `WAIT_STATES`, 2: extra cycles per access, range 0..15.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `clr`  in  1  reset; asynchronous, active-low.
- `Address`  in  32  word address, taken from MAR.
- `Read`  in  1  read strobe, level.
- `Write`  in  1  write strobe, level.
- `Data_in`  in  DATA_W  write data, taken from MDR.
- `Mdatain`  out  DATA_W  read data register, feeds the MDR input mux.
- `Ready`  out  1  one-cycle completion pulse.
- `Busy`  out  1  high while a transaction is in flight.
- `Err`  out  1  one-cycle error pulse, coincident with `Ready`.

## Operation
- States: IDLE, WAIT, DONE.
- Request detect: `req = (Read|Write) & ~prev`, where `prev` is the registered `Read|Write` from the previous edge.
  - `prev` updates on every edge, in every state.
  - A strobe held high across or after a transaction never retriggers.
- IDLE, `req`=1: latch `Address`, `Data_in` and the op.
  - Set `Busy`=1.
  - Go to WAIT with counter = WAIT_STATES, or straight to DONE if WAIT_STATES = 0.
- WAIT: decrement the counter each edge. When the counter reaches 1 on an edge, go to DONE on that edge.
- DONE (one cycle): perform the access, then return to IDLE on the next edge.
  - Read: `Mdatain` <= mem[addr].
  - Write: mem[addr] <= latched data; `Mdatain` unchanged.
  - `Ready`=1 and `Busy`=0 during this cycle.
- Error cases (`Err`=1 together with `Ready`):
  - `Read` and `Write` both high at the accept edge: no access; `Mdatain` unchanged.
  - Address >= DEPTH: write dropped; a read loads `Mdatain` = 0.
- `Mdatain` holds the last completed read value until the next read completes.
- Strobe rising edges while `Busy`=1 are dropped silently: no queueing, no `Err`. `prev` still tracks them.
- Memory array is not cleared by `clr`; contents after power-up are undefined.

## Timing
- Reset values (asynchronous on `clr`=0): state IDLE, `Mdatain`=0, `Ready`=0, `Busy`=0, `Err`=0, `prev`=0, counter=0.
- Reset mid-transaction aborts immediately; a pending write is not committed.
- For a request accepted at edge N:
  - `Busy` is high from edge N to edge N+W.
  - `Ready`/`Err` are high from edge N+W to edge N+W+1.
  - Read data is valid on `Mdatain` from edge N+W+1.
  - A write commits at edge N+W+1.
- Latency from accept edge to data valid is W+1 cycles. With W=0, `Ready` is high in the cycle right after acceptance.
- Earliest next accept is edge N+W+2, and only if the strobe was sampled low at some edge after N.
- The datapath should assert MDRin with `Read` and keep MDRin high through the `Ready` cycle.

## Test plan
- Reset: hold `clr`=0 with random inputs → all outputs 0. Release → a `Read` 2 cycles later is accepted normally.
- Write then read, W=2:
  - Write 0x0000000D to address 6; `Ready` pulses 2 cycles after the accept edge.
  - Pulse `Read` on address 6 → `Mdatain`=0x0000000D at accept+3.
  - `Busy` is high for exactly 2 cycles each time.
- Held strobe: hold `Read` high for 10 cycles, address 5 containing 0x5 → exactly one `Ready` pulse; `Mdatain`=0x5.
- Error cases:
  - `Read`=`Write`=1 at address 3 → `Err` and `Ready` pulse; mem[3] and `Mdatain` unchanged.
  - Read at address 600 (DEPTH=512) → `Err`; `Mdatain`=0.
- Reset mid-transaction: start a write of 0xFFFFFFFF to address 9 (old value 0x1), W=4; assert `clr` at accept+2 → mem[9] still reads 0x1 afterwards.
- W=0 back-to-back: `Read` pulses alternating high/low on each edge with addresses 0,1,2 → three `Ready` pulses, each one cycle after its accept edge, returning the correct data.
